// File: rtl/game_flow_ctrl.sv
// Top-level game-flow FSM: menu, mode select, controls, level intro, gameplay,
// game-over and victory screens, plus a registered screen-layer pixel mux.
module game_flow_ctrl #(
    parameter int NUM_MODES    = 2,
    parameter int NUM_LEVELS   = 3,
    parameter int INTRO_FRAMES = 60,
    parameter int HOLD_FRAMES  = 30,
    parameter int WRAP_SEL     = 1,
    localparam int MODE_W = (NUM_MODES > 2) ? $clog2(NUM_MODES) : 1,
    localparam int LVL_W  = (NUM_LEVELS > 2) ? $clog2(NUM_LEVELS) : 1
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              startOfFrame,
    input  logic              enter_key,
    input  logic              up_key,
    input  logic              down_key,
    input  logic              back_key,
    input  logic              timer_ended,
    input  logic              player_died,
    input  logic              level_cleared,
    input  logic              menu_DR,
    input  logic [7:0]        menu_RGB,
    input  logic              select_DR,
    input  logic [7:0]        select_RGB,
    input  logic              controls_DR,
    input  logic [7:0]        controls_RGB,
    input  logic              intro_DR,
    input  logic [7:0]        intro_RGB,
    input  logic              gameover_DR,
    input  logic [7:0]        gameover_RGB,
    input  logic              victory_DR,
    input  logic [7:0]        victory_RGB,
    input  logic [7:0]        RGB_MIF,
    output logic [7:0]        RGBOut,
    output logic              game_on,
    output logic              level_start,
    output logic [MODE_W-1:0] mode_sel,
    output logic [LVL_W-1:0]  level,
    output logic [1:0]        over_cause,
    output logic [2:0]        state_code
);

    localparam logic [2:0] S_MAIN     = 3'd0;
    localparam logic [2:0] S_SELECT   = 3'd1;
    localparam logic [2:0] S_CONTROLS = 3'd2;
    localparam logic [2:0] S_INTRO    = 3'd3;
    localparam logic [2:0] S_PLAY     = 3'd4;
    localparam logic [2:0] S_OVER     = 3'd5;
    localparam logic [2:0] S_VICTORY  = 3'd6;

    localparam logic [MODE_W-1:0] MODE_MAX  = MODE_W'(NUM_MODES - 1);
    localparam logic [LVL_W-1:0]  LVL_LAST  = LVL_W'(NUM_LEVELS - 1);
    localparam logic [7:0]        INTRO_CNT = 8'(INTRO_FRAMES);
    localparam logic [7:0]        HOLD_CNT  = 8'(HOLD_FRAMES);

    logic [2:0]        state, state_nx;
    logic [7:0]        frame_cnt, frame_cnt_nx;
    logic [MODE_W-1:0] mode_nx;
    logic [LVL_W-1:0]  level_nx;
    logic [1:0]        cause_nx;
    logic [3:0]        keys, key_q, rise;
    logic [7:0]        pix_nx;

    // Bit order {down, up, back, enter}; the FSM's if/else chain gives enter priority.
    assign keys       = {down_key, up_key, back_key, enter_key};
    assign rise       = keys & ~key_q;
    assign state_code = state;

    always_comb begin
        state_nx     = state;
        frame_cnt_nx = frame_cnt;
        mode_nx      = mode_sel;
        level_nx     = level;
        cause_nx     = over_cause;
        case (state)
            S_MAIN: begin
                if (rise[0]) state_nx = S_SELECT;
            end
            S_SELECT: begin
                if (rise[0]) begin
                    state_nx = S_CONTROLS;
                end else if (rise[1]) begin
                    state_nx = S_MAIN;
                end else if (rise[2]) begin
                    if (mode_sel == '0) mode_nx = (WRAP_SEL != 0) ? MODE_MAX : '0;
                    else                mode_nx = mode_sel - MODE_W'(1);
                end else if (rise[3]) begin
                    if (mode_sel == MODE_MAX) mode_nx = (WRAP_SEL != 0) ? '0 : MODE_MAX;
                    else                      mode_nx = mode_sel + MODE_W'(1);
                end
            end
            S_CONTROLS: begin
                if (rise[0]) begin
                    state_nx     = S_INTRO;
                    level_nx     = '0;
                    frame_cnt_nx = '0;
                end else if (rise[1]) begin
                    state_nx = S_SELECT;
                end
            end
            S_INTRO: begin
                if (frame_cnt == INTRO_CNT) state_nx = S_PLAY;
                else if (startOfFrame)      frame_cnt_nx = frame_cnt + 8'd1;
            end
            S_PLAY: begin
                if (player_died) begin
                    state_nx     = S_OVER;
                    cause_nx     = 2'd2;
                    frame_cnt_nx = '0;
                end else if (timer_ended) begin
                    state_nx     = S_OVER;
                    cause_nx     = 2'd1;
                    frame_cnt_nx = '0;
                end else if (level_cleared) begin
                    frame_cnt_nx = '0;
                    if (level == LVL_LAST) begin
                        state_nx = S_VICTORY;
                    end else begin
                        state_nx = S_INTRO;
                        level_nx = level + LVL_W'(1);
                    end
                end
            end
            S_OVER, S_VICTORY: begin
                // Enter edges during the hold window are dropped, not remembered.
                if (frame_cnt == HOLD_CNT) begin
                    if (rise[0]) begin
                        state_nx     = S_MAIN;
                        level_nx     = '0;
                        mode_nx      = '0;
                        cause_nx     = 2'd0;
                        frame_cnt_nx = '0;
                    end
                end else if (startOfFrame) begin
                    frame_cnt_nx = frame_cnt + 8'd1;
                end
            end
            default: begin
                state_nx     = S_MAIN;
                frame_cnt_nx = '0;
                mode_nx      = '0;
                level_nx     = '0;
                cause_nx     = 2'd0;
            end
        endcase
    end

    always_comb begin
        pix_nx = RGB_MIF;
        case (state)
            S_MAIN:     if (menu_DR)     pix_nx = menu_RGB;
            S_SELECT:   if (select_DR)   pix_nx = select_RGB;
            S_CONTROLS: if (controls_DR) pix_nx = controls_RGB;
            S_INTRO:    if (intro_DR)    pix_nx = intro_RGB;
            S_PLAY:     pix_nx = RGB_MIF;
            S_OVER:     if (gameover_DR) pix_nx = gameover_RGB;
            S_VICTORY:  if (victory_DR)  pix_nx = victory_RGB;
            default:    pix_nx = 8'h00;
        endcase
    end

    // game_on/level_start are registered from the next state so they track state exactly.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= S_MAIN;
            frame_cnt   <= '0;
            mode_sel    <= '0;
            level       <= '0;
            over_cause  <= 2'd0;
            key_q       <= 4'hF;
            game_on     <= 1'b0;
            level_start <= 1'b0;
            RGBOut      <= 8'h00;
        end else begin
            state       <= state_nx;
            frame_cnt   <= frame_cnt_nx;
            mode_sel    <= mode_nx;
            level       <= level_nx;
            over_cause  <= cause_nx;
            key_q       <= keys;
            game_on     <= (state_nx == S_PLAY);
            level_start <= (state_nx == S_PLAY) && (state != S_PLAY);
            RGBOut      <= pix_nx;
        end
    end

endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Parametrised top-level game-flow controller. It sequences the main menu, an N-way mode selection, the controls screen, per-level intro, gameplay, game-over and victory screens. It detects rising edges on the keys internally and tracks the current level. Per cycle it multiplexes the active screen layer, or the background, onto the shared RGB output, and it drives `game_on` and level information to the gameplay blocks.

## Interface
- `NUM_MODES`, 2: number of selectable modes (2..8); `MODE_W = max(1, clog2(NUM_MODES))`.
- `NUM_LEVELS`, 3: levels per run (1..15); `LVL_W = max(1, clog2(NUM_LEVELS))`.
- `INTRO_FRAMES`, 60: frames the level-intro screen is shown (1..255).
- `HOLD_FRAMES`, 30: frames before Enter is accepted on game-over/victory (0..255).
- `WRAP_SEL`, 1: 1 = mode selection wraps at the ends; 0 = it saturates.
- `clk`, in, 1: system clock.
- `resetN`, in, 1: asynchronous, active-low reset.
- `startOfFrame`, in, 1: one-cycle pulse per video frame.
- `enter_key`, `up_key`, `down_key`, `back_key`, in, 1 each: level-sensitive key states, synchronous to `clk`.
- `timer_ended`, `player_died`, `level_cleared`, in, 1 each: gameplay events, level-sensitive.
- `menu_DR`, `menu_RGB[7:0]`, in: main-menu layer.
- `select_DR`, `select_RGB[7:0]`, in: mode-select layer; the drawer highlights `mode_sel`.
- `controls_DR`, `controls_RGB[7:0]`, in: controls layer.
- `intro_DR`, `intro_RGB[7:0]`, in: level-intro layer; the drawer shows `level`.
- `gameover_DR`, `gameover_RGB[7:0]`, in: game-over layer; the drawer shows `over_cause`.
- `victory_DR`, `victory_RGB[7:0]`, in: victory layer.
- `RGB_MIF[7:0]`, in: background/gameplay pixel.
- `RGBOut[7:0]`, out: registered pixel.
- `game_on`, out, 1: high only in GAMEPLAY.
- `level_start`, out, 1: one-cycle pulse on every entry to GAMEPLAY.
- `mode_sel[MODE_W-1:0]`, out: current or committed mode.
- `level[LVL_W-1:0]`, out: current level, 0-based.
- `over_cause[1:0]`, out: 0 none, 1 time, 2 lives.
- `state_code[2:0]`, out: encoding of the current state.

## Operation
- Key edges: `rise = key & ~key_q`. The `key_q` registers reset to 1, so a key held through reset produces no edge.
- Key priority within one cycle: enter > back > up > down. Only one key edge acts per cycle.
- State encodings for `state_code`: MAIN_MENU = 0, MODE_SELECT = 1, CONTROLS = 2, LEVEL_INTRO = 3, GAMEPLAY = 4, GAMEOVER = 5, VICTORY = 6.
- MAIN_MENU: enter edge → MODE_SELECT.
- MODE_SELECT: up edge decrements `mode_sel`, down edge increments it.
  - At the ends: with `WRAP_SEL=1`, 0 → NUM_MODES-1 and back; with `WRAP_SEL=0` the value holds.
  - Enter edge → CONTROLS, and `mode_sel` freezes.
  - Back edge → MAIN_MENU.
- CONTROLS: enter edge → LEVEL_INTRO with `level`=0 and the frame counter cleared. Back edge → MODE_SELECT.
- LEVEL_INTRO: counts `startOfFrame` pulses. When the count reaches INTRO_FRAMES, the next cycle → GAMEPLAY, with `game_on`=1 and `level_start`=1 for one cycle. Keys are ignored.
- GAMEPLAY: same-cycle event priority is player_died > timer_ended > level_cleared.
  - player_died → GAMEOVER with `over_cause`=2.
  - timer_ended → GAMEOVER with `over_cause`=1.
  - level_cleared on `level`=NUM_LEVELS-1 → VICTORY; otherwise `level`+1 → LEVEL_INTRO.
  - `game_on` drops in the same cycle the state leaves GAMEPLAY.
  - Events are sampled only in GAMEPLAY, so a level held high elsewhere is ignored.
- GAMEOVER and VICTORY:
  - The frame counter clears on entry and saturates at HOLD_FRAMES.
  - An enter edge while the counter is below HOLD_FRAMES is discarded, not queued.
  - An enter edge once the count has reached HOLD_FRAMES → MAIN_MENU, clearing `level`, `mode_sel` and `over_cause`.
  - Back edge is ignored.
- RGB mux, registered: `RGBOut <=` the active layer's RGB if its DR is high, else `RGB_MIF`. GAMEPLAY always passes `RGB_MIF`.
- Unused state encodings (7) → MAIN_MENU on the next cycle, with outputs cleared.

## Timing
- Reset (async, any state or mid-count): state MAIN_MENU, `RGBOut`=0, `game_on`=0, `level_start`=0, `mode_sel`=0, `level`=0, `over_cause`=0, `state_code`=0, frame counter 0, `key_q`=1.
- Key edge at cycle n → new state and `state_code` at n+1. Screen RGB follows from n+2.
- `RGBOut` latency: 1 cycle from the DR/RGB inputs.
- LEVEL_INTRO residence: from entry to the cycle after the INTRO_FRAMES-th `startOfFrame`.
- `level_start` is high exactly in the first GAMEPLAY cycle.
- A `startOfFrame` in the entry cycle of LEVEL_INTRO/GAMEOVER/VICTORY is not counted.
- A key held across a state change generates no second edge.

## Test plan
- Reset with enter held, then release and press: no transition while held from reset; one press → MODE_SELECT (`state_code`=1) one cycle after the edge.
- Mode select with NUM_MODES=3, WRAP_SEL=1: down ×3 → `mode_sel` 1, 2, 0; up → 2. With WRAP_SEL=0: up at 0 holds 0, down at 2 holds 2.
- Flow through levels: enter → CONTROLS, enter → LEVEL_INTRO.
  - `game_on` rises after exactly INTRO_FRAMES=4 frame pulses, with a one-cycle `level_start`.
  - level_cleared ×3 with NUM_LEVELS=3 → `level` 1, 2, then VICTORY (`state_code`=6).
- player_died and timer_ended in the same cycle: → GAMEOVER with `over_cause`=2 and `game_on`=0 next cycle. Then, with HOLD_FRAMES=2, an enter edge after 1 frame is ignored and an enter edge after 2 frames → MAIN_MENU with `level`=0 and `mode_sel`=0.
- RGB mux in MAIN_MENU: `menu_DR`=1 with `menu_RGB`=8'hE0 → `RGBOut`=8'hE0 one cycle later; `menu_DR`=0 with `RGB_MIF`=8'h1C → 8'h1C.
- Back key: back in CONTROLS → MODE_SELECT; back in MODE_SELECT → MAIN_MENU; enter and back in the same cycle: enter wins.
